demux_1_4_stream: RTL

//   Registered 1:4 stream demultiplexer; the routing counterpart of mux_4_1.

---
 rtl/demux_pkg.sv | 15 +
 rtl/stream_skid_reg.sv | 57 +++++
 rtl/demux_1_4_stream.sv | 70 +++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1:4 stream demultiplexer.
package demux_pkg;

   localparam int N_OUT = 4;

   typedef logic [1:0] sel_t;

   function automatic logic [3:0] onehot4(input sel_t sel);
      logic [3:0] oh;
      oh = 4'b0000;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/stream_skid_reg.sv
// Generic 2-entry valid/ready skid buffer: a main output register backed by
// one skid entry, so in_ready is a flop and never sees out_ready combinationally.
module stream_skid_reg #(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [PW-1:0] out_data
);

   logic          main_valid;
   logic          skid_valid;
   logic [PW-1:0] main_data;
   logic [PW-1:0] skid_data;
   logic          accept;
   logic          drain;
   logic          main_free;

   assign in_ready  = ~skid_valid;
   assign accept    = in_valid & ~skid_valid;
   assign drain     = main_valid & out_ready;
   assign main_free = ~main_valid | drain;

   assign out_valid = main_valid;
   assign out_data  = main_data;

   // The skid entry only fills while main is stalled, so it always holds the
   // older word and must move to main before anything new is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
      end else if (main_free) begin
         if (skid_valid) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
         end else begin
            main_valid <= accept;
            if (accept) begin
               main_data <= in_data;
            end
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
   end

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1:4 stream demultiplexer: routes each tagged word to one of four
// lanes in strict input order and counts deliveries per lane.
module demux_1_4_stream
   import demux_pkg::*;
#(
   parameter int W  = 4,
   parameter int CW = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     up_valid,
   output logic                     up_ready,
   input  logic [W-1:0]             up_data,
   input  logic [1:0]               up_sel,
   output logic [N_OUT-1:0]         dn_valid,
   input  logic [N_OUT-1:0]         dn_ready,
   output logic [N_OUT-1:0][W-1:0]  dn_data,
   input  logic                     cnt_clr,
   output logic [N_OUT-1:0][CW-1:0] cnt
);

   localparam int PW = W + 2;

   logic [PW-1:0]    main_word;
   logic             main_valid;
   logic             main_ready;
   sel_t             main_sel;
   logic [W-1:0]     main_data;
   logic [N_OUT-1:0] lane_hs;

   stream_skid_reg #(
      .PW(PW)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (up_valid),
      .in_ready  (up_ready),
      .in_data   ({up_sel, up_data}),
      .out_valid (main_valid),
      .out_ready (main_ready),
      .out_data  (main_word)
   );

   assign main_sel  = main_word[PW-1 -: 2];
   assign main_data = main_word[W-1:0];

   // Only the selected lane's ready matters, which gives head-of-line blocking.
   assign dn_valid   = main_valid ? onehot4(main_sel) : '0;
   assign main_ready = dn_ready[main_sel];
   assign lane_hs    = dn_valid & dn_ready;

   for (genvar i = 0; i < N_OUT; i++) begin : g_lane
      logic [CW-1:0] lane_cnt;

      assign dn_data[i] = dn_valid[i] ? main_data : '0;
      assign cnt[i]     = lane_cnt;

      // Clear takes priority over a coinciding handshake.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            lane_cnt <= '0;
         end else if (cnt_clr) begin
            lane_cnt <= '0;
         end else if (lane_hs[i]) begin
            lane_cnt <= lane_cnt + CW'(1);
         end
      end
   end

endmodule
